// File: rtl/mem_pkg.sv
// Shared types for the memory-handle server: FSM state encoding, posted-write
// entry layout and default address/data widths.
package mem_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_MEM_RD,
        S_RESP,
        S_ACK
    } mem_state_e;

    // Layout of one posted-write entry at the default widths.
    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] data;
        logic              valid;
    } pb_entry_t;

endpackage

// File: rtl/mem_post_buffer.sv
// Single-entry posted-write buffer: holds one {addr, data} pair and reports a
// full-width address hit against the incoming handle pointer.
module mem_post_buffer
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          load_i,
    input  logic          clr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic [AW-1:0] cmp_addr_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    output logic          hit_o
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    // A load always wins: the FSM never loads and clears in the same cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign hit_o   = valid_q && (addr_q == cmp_addr_i);

endmodule

// File: rtl/mem_handle_server.sv
// Memory-handle server: one client request at a time, posted-write buffer in
// front of a req/ack backing port. Optional MEM_HANDLE_BOUNDS_CHECK_EN adds a
// region check that fails out-of-range requests with h_err.
module mem_handle_server
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          h_avail,
    input  logic          h_w_en,
    input  logic          h_r_en,
    input  logic [AW-1:0] h_ptr,
    input  logic [DW-1:0] h_data_store,
    input  logic          h_write_through,
    input  logic          h_read_through,
    output logic [DW-1:0] h_data_load,
    output logic          h_done,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
    ,
    input  logic [AW-1:0] h_region_begin,
    input  logic [AW-1:0] h_region_end,
    output logic          h_err
`endif
);

    mem_state_e    state_q;
    logic          req_act_q;   // current DRAIN belongs to the accepted request
    logic          req_wt_q;    // that request is a write-through (else read-through)
    logic [AW-1:0] req_addr_q;
    logic [DW-1:0] load_q;
    logic          done_q;
    logic          m_req_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
    logic          err_pend_q;
    logic          err_q;
`endif

    logic          pb_valid;
    logic [AW-1:0] pb_addr;
    logic [DW-1:0] pb_data;
    logic          pb_hit;
    logic          pb_load;
    logic          pb_clr;
    logic          accept;
    logic          in_range;

`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
    assign in_range = (h_ptr >= h_region_begin) && (h_ptr <= h_region_end);
`else
    assign in_range = 1'b1;
`endif

    assign accept  = (state_q == S_IDLE) && h_avail && (h_w_en || h_r_en);
    // A write may only enter the buffer when it is empty or holds the same word.
    assign pb_load = accept && in_range && h_w_en && !(pb_valid && !pb_hit);
    assign pb_clr  = (state_q == S_DRAIN) && m_req_q && m_ack;

    mem_post_buffer #(.AW(AW), .DW(DW)) u_pb (
        .clk        (clk),
        .rst_l      (rst_l),
        .load_i     (pb_load),
        .clr_i      (pb_clr),
        .addr_i     (h_ptr),
        .data_i     (h_data_store),
        .cmp_addr_i (h_ptr),
        .valid_o    (pb_valid),
        .addr_o     (pb_addr),
        .data_o     (pb_data),
        .hit_o      (pb_hit)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= S_IDLE;
            req_act_q  <= 1'b0;
            req_wt_q   <= 1'b0;
            req_addr_q <= '0;
            load_q     <= '0;
            done_q     <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_addr_q <= h_ptr;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
                        err_pend_q <= !in_range;
`endif
                        if (!in_range) begin
                            state_q <= S_RESP;
                        end else if (h_w_en) begin
                            if (pb_valid && !pb_hit) begin
                                // Evict the other word, then retry this write from IDLE.
                                req_act_q <= 1'b0;
                                state_q   <= S_DRAIN;
                            end else if (h_write_through) begin
                                req_act_q <= 1'b1;
                                req_wt_q  <= 1'b1;
                                state_q   <= S_DRAIN;
                            end else begin
                                state_q <= S_RESP;
                            end
                        end else if (pb_hit && !h_read_through) begin
                            load_q  <= pb_data;
                            state_q <= S_RESP;
                        end else if (pb_hit) begin
                            req_act_q <= 1'b1;
                            req_wt_q  <= 1'b0;
                            state_q   <= S_DRAIN;
                        end else begin
                            state_q <= S_MEM_RD;
                        end
                    end else if (pb_valid) begin
                        req_act_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end
                end
                // Requests are issued one cycle after entry, which also guarantees an
                // idle cycle between a drain and the following read.
                S_DRAIN: begin
                    if (!m_req_q) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b1;
                        m_addr_q  <= pb_addr;
                        m_wdata_q <= pb_data;
                    end else if (m_ack) begin
                        m_req_q <= 1'b0;
                        if (!req_act_q) begin
                            state_q <= S_IDLE;
                        end else if (req_wt_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_ACK;
                        end else begin
                            state_q <= S_MEM_RD;
                        end
                    end
                end
                S_MEM_RD: begin
                    if (!m_req_q) begin
                        m_req_q  <= 1'b1;
                        m_we_q   <= 1'b0;
                        m_addr_q <= req_addr_q;
                    end else if (m_ack) begin
                        m_req_q <= 1'b0;
                        load_q  <= m_rdata;
                        done_q  <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_RESP: begin
                    done_q  <= 1'b1;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
                    err_q   <= err_pend_q;
`endif
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    if (!h_avail) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign h_data_load = load_q;
    assign h_done      = done_q;
    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
    assign h_err       = err_q;
`endif

endmodule

// File: tb/tb_mem_handle_server.sv
// Scoreboard bench for mem_handle_server: directed scenarios followed by random
// traffic checked against an architectural memory model.
`timescale 1ns/1ps
module tb_mem_handle_server;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          h_avail = 1'b0;
    logic          h_w_en = 1'b0;
    logic          h_r_en = 1'b0;
    logic [AW-1:0] h_ptr = '0;
    logic [DW-1:0] h_data_store = '0;
    logic          h_write_through = 1'b0;
    logic          h_read_through = 1'b0;
    logic [DW-1:0] h_data_load;
    logic          h_done;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ack = 1'b0;
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
    logic [AW-1:0] h_region_begin = '0;
    logic [AW-1:0] h_region_end = '1;
    logic          h_err;
`endif

    mem_handle_server #(.AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .h_avail         (h_avail),
        .h_w_en          (h_w_en),
        .h_r_en          (h_r_en),
        .h_ptr           (h_ptr),
        .h_data_store    (h_data_store),
        .h_write_through (h_write_through),
        .h_read_through  (h_read_through),
        .h_data_load     (h_data_load),
        .h_done          (h_done),
        .m_req           (m_req),
        .m_we            (m_we),
        .m_addr          (m_addr),
        .m_wdata         (m_wdata),
        .m_rdata         (m_rdata),
        .m_ack           (m_ack)
`ifdef MEM_HANDLE_BOUNDS_CHECK_EN
        ,
        .h_region_begin  (h_region_begin),
        .h_region_end    (h_region_end),
        .h_err           (h_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Architectural model: latest value written per address; unwritten words
    // read back their backing-memory initial value.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bmem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a * 3 + 32'h1000;
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] bmem_val(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_val(a);
    endfunction

    // Backing memory responder
    bit          ack_en = 1'b1;
    int          lat_fixed = -1;
    bit          force_rd = 1'b0;
    logic [31:0] force_val = '0;
    int          last_ack_cyc = 0;
    int          n_mem_rd = 0;
    int          n_mem_wr = 0;
    int          req_cyc_cnt = 0;
    logic        lg_we[$];
    logic [31:0] lg_addr[$];
    logic [31:0] lg_data[$];
    bit          rs_pend = 1'b0;
    bit          rs_stable = 1'b1;
    int          rs_wleft = 0;
    logic [31:0] rs_a;
    logic [31:0] rs_d;
    logic        rs_w;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            if (!rst_l || !m_req) begin
                rs_pend = 1'b0;
            end else begin
                if (!rs_pend) begin
                    rs_pend = 1'b1;
                    rs_a = m_addr;
                    rs_d = m_wdata;
                    rs_w = m_we;
                    rs_stable = 1'b1;
                    rs_wleft = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
                end else if (m_addr !== rs_a || m_we !== rs_w || (rs_w && m_wdata !== rs_d)) begin
                    rs_stable = 1'b0;
                end
                if (ack_en && rs_wleft == 0) begin
                    chk("mem_req_stable", rs_stable, 1);
                    if (rs_w) begin
                        bmem[rs_a] = rs_d;
                        n_mem_wr++;
                    end else begin
                        m_rdata = force_rd ? force_val : bmem_val(rs_a);
                        n_mem_rd++;
                    end
                    lg_we.push_back(rs_w);
                    lg_addr.push_back(rs_a);
                    lg_data.push_back(rs_w ? rs_d : m_rdata);
                    m_ack = 1'b1;
                    rs_pend = 1'b0;
                    last_ack_cyc = cyc;
                end else if (rs_wleft > 0) begin
                    rs_wleft--;
                end
            end
        end
    end

    always @(negedge clk) if (m_req) req_cyc_cnt++;

    // Scoreboard
    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_load = '0;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst_l && h_done) begin
            chk("done_pulse", prev_done, 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                $display("[%0d] done %s ptr=0x%0h load=0x%0h", cyc, mon_e.is_rd ? "rd" : "wr", h_ptr, h_data_load);
                chk(mon_e.is_rd ? "rd_data" : "wr_keeps_load", h_data_load, mon_e.data);
            end
        end
        prev_done = h_done;
    end

    int avail_cyc = 0;
    int done_cyc = 0;

    task automatic do_req(input bit we, input bit re, input logic [31:0] ptr, input logic [31:0] d,
                          input bit wt, input bit rt, input bit ovr, input logic [31:0] ovr_val);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(posedge clk);
        #1;
        if (we) begin
            ref_mem[ptr] = d;
            e.is_rd = 1'b0;
            e.data  = last_load;
        end else begin
            e.is_rd = 1'b1;
            e.data  = ovr ? ovr_val : ref_val(ptr);
            last_load = e.data;
        end
        sb.push_back(e);
        h_w_en = we;
        h_r_en = re;
        h_ptr = ptr;
        h_data_store = d;
        h_write_through = wt;
        h_read_through = rt;
        h_avail = 1'b1;
        avail_cyc = cyc;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if (h_done) begin
                got = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!got) begin
            chk("req_timeout", 0, 1);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        h_avail = 1'b0;
        h_w_en = 1'b0;
        h_r_en = 1'b0;
    endtask

    task automatic wait_mreq(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (m_req) seen = 1'b1;
        end
    endtask

    int          li;
    int          snap_rd;
    int          snap_wr;
    bit          seen;
    logic [31:0] r_a;
    logic [31:0] r_d;
    bit          r_we;
    bit          r_re;
    bit          r_wt;
    bit          r_rt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", h_done, 0);
        chk("rst_mreq", m_req, 0);
        chk("rst_mwe", m_we, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_mwdata", m_wdata, 0);
        chk("rst_load", h_data_load, 0);
        @(negedge clk);
        rst_l = 1'b1;

        // Posted write with no ack: done after 2 cycles, drain only once avail drops
        ack_en = 1'b0;
        do_req(1, 0, 32'h10, 32'hA5, 0, 0, 0, 0);
        chk("post_latency", done_cyc - avail_cyc, 2);
        chk("no_mreq_while_avail", req_cyc_cnt, 0);
        wait_mreq(seen);
        chk("idle_drain_seen", seen, 1);
        chk("idle_drain_we", m_we, 1);
        chk("idle_drain_addr", m_addr, 32'h10);
        chk("idle_drain_wdata", m_wdata, 32'hA5);
        ack_en = 1'b1;
        repeat (15) @(posedge clk);

        // Forwarded read from the posted buffer
        do_req(1, 0, 32'h20, 32'h11, 0, 0, 0, 0);
        snap_rd = n_mem_rd;
        snap_wr = n_mem_wr;
        do_req(0, 1, 32'h20, 0, 0, 0, 0, 0);
        chk("fwd_no_mem_rd", n_mem_rd, snap_rd);
        chk("fwd_no_mem_wr", n_mem_wr, snap_wr);
        repeat (15) @(posedge clk);

        // Read-through on a buffered word: drain then memory read
        do_req(1, 0, 32'h20, 32'h11, 0, 0, 0, 0);
        li = lg_we.size();
        force_rd = 1'b1;
        force_val = 32'h77;
        do_req(0, 1, 32'h20, 0, 0, 1, 1, 32'h77);
        force_rd = 1'b0;
        chk("rt_mem_ops", lg_we.size(), li + 2);
        if (lg_we.size() >= li + 2) begin
            chk("rt_drain_we", lg_we[li], 1);
            chk("rt_drain_addr", lg_addr[li], 32'h20);
            chk("rt_drain_data", lg_data[li], 32'h11);
            chk("rt_read_we", lg_we[li+1], 0);
            chk("rt_read_addr", lg_addr[li+1], 32'h20);
        end
        repeat (15) @(posedge clk);

        // Conflicting posted write evicts the older word first
        li = lg_we.size();
        do_req(1, 0, 32'h30, 32'h1, 0, 0, 0, 0);
        do_req(1, 0, 32'h31, 32'h2, 0, 0, 0, 0);
        chk("evict_ops", lg_we.size(), li + 1);
        if (lg_we.size() >= li + 1) begin
            chk("evict_addr", lg_addr[li], 32'h30);
            chk("evict_data", lg_data[li], 32'h1);
        end
        chk("evict_before_done", done_cyc > last_ack_cyc, 1);
        repeat (15) @(posedge clk);

        // Write-through with a slow ack
        lat_fixed = 5;
        do_req(1, 0, 32'h40, 32'hDEAD, 1, 0, 0, 0);
        chk("wt_done_after_ack", done_cyc - last_ack_cyc, 1);
        chk("wt_committed", bmem_val(32'h40), 32'hDEAD);
        lat_fixed = -1;
        repeat (15) @(posedge clk);

        // Reset during MEM_RD discards the posted write and the in-flight read
        do_req(1, 0, 32'h58, 32'h99, 0, 0, 0, 0);
        ack_en = 1'b0;
        @(posedge clk);
        #1;
        h_w_en = 1'b0;
        h_r_en = 1'b1;
        h_ptr = 32'h50;
        h_read_through = 1'b0;
        h_avail = 1'b1;
        wait_mreq(seen);
        chk("rst_mid_rd_seen", seen, 1);
        chk("rst_mid_rd_we", m_we, 0);
        chk("rst_mid_rd_addr", m_addr, 32'h50);
        rst_l = 1'b0;
        #1;
        chk("rst_async_mreq", m_req, 0);
        chk("rst_async_done", h_done, 0);
        h_avail = 1'b0;
        h_r_en = 1'b0;
        ref_mem.delete(32'h58);
        last_load = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        ack_en = 1'b1;
        snap_wr = n_mem_wr;
        repeat (15) @(posedge clk);
        chk("rst_discard_posted", n_mem_wr, snap_wr);
        chk("rst_no_0x58", bmem.exists(32'h58), 0);
        do_req(0, 1, 32'h50, 0, 0, 0, 0, 0);

        // Random traffic over a small address window
        for (int n = 0; n < 150; n++) begin
            r_a  = 32'h100 + $urandom_range(0, 7);
            r_d  = $urandom;
            r_we = ($urandom_range(0, 1) == 1);
            r_re = !r_we || ($urandom_range(0, 3) == 0);
            r_wt = ($urandom_range(0, 3) == 0);
            r_rt = ($urandom_range(0, 2) == 0);
            do_req(r_we, r_re, r_a, r_d, r_wt, r_rt, 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Everything written must eventually reach backing memory
        repeat (40) @(posedge clk);
        foreach (ref_mem[a]) chk("final_flush", bmem_val(a), ref_mem[a]);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
